// File: rtl/link_arb_pkg.sv
// Shared types and helpers for the N-to-1 link arbiter.
package link_arb_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // True on the final beat of a burst of 'beats' beats.
  function automatic logic is_last_beat(input logic [CNT_W-1:0] dcnt,
                                        input int unsigned       beats);
    return dcnt == CNT_W'(beats - 1);
  endfunction

endpackage

// File: rtl/link_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module link_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The upper copy of the request vector supplies the wrapped-around candidates.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// Shares one downstream link responder among N DMA channels with round-robin
// grant held from request through the last data beat of the burst.
module link_arbiter
  import link_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           m_req,
  input  logic [N*ADDR_W-1:0]    m_addr,
  output logic [N-1:0]           m_ack,
  output logic [N-1:0]           m_dvld,
  output logic [DATA_W-1:0]      m_rdata,
  output logic [CNT_W-1:0]       m_dcnt,
  output logic                   s_req,
  output logic [ADDR_W-1:0]      s_addr,
  input  logic                   s_ack,
  input  logic                   s_dvld,
  input  logic [DATA_W-1:0]      s_rdata,
  input  logic [CNT_W-1:0]       s_dcnt,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [TMR_W-1:0]   timer;
  logic               err_q;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               in_req;
  logic               in_data;
  logic [ADDR_W-1:0]  addr_arr [N];

  link_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (m_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr = (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      timer  <= '0;
      err_q  <= 1'b0;
    end else begin
      // Data valid outside DATA has no owner; flag it and otherwise ignore it.
      err_q <= s_dvld && (state != DATA);
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= REQ;
          end
        end
        REQ: begin
          if (s_ack) begin
            state <= DATA;
            timer <= '0;
          end else if (!m_req[grant]) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (s_dvld) begin
            timer <= '0;
            if (is_last_beat(s_dcnt, BEATS)) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            // Responder went silent; release the link and move the pointer on.
            err_q  <= 1'b1;
            timer  <= '0;
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so the link is quiet immediately.
  assign in_req  = rst_n && (state == REQ);
  assign in_data = rst_n && (state == DATA);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_arr[i] = m_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    m_ack  = '0;
    m_dvld = '0;
    if (in_req) begin
      m_ack[grant] = s_ack;
    end
    if (in_data) begin
      m_dvld[grant] = s_dvld;
    end
  end

  assign s_req    = in_req;
  assign s_addr   = in_req ? addr_arr[grant] : '0;
  assign m_rdata  = in_data ? s_rdata : '0;
  assign m_dcnt   = in_data ? s_dcnt : '0;
  assign busy     = rst_n && (state != IDLE);
  assign grant_id = rst_n ? grant : '0;
  assign err      = rst_n && err_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: expected grants/beats are queued when
// stimulus is driven and compared as the arbiter presents them.
module tb_link_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BEATS = 8;
  localparam int unsigned TMO   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_dvld;
  logic [DW-1:0]   m_rdata;
  logic [2:0]      m_dcnt;
  logic            s_req;
  logic [AW-1:0]   s_addr;
  logic            s_ack;
  logic            s_dvld;
  logic [DW-1:0]   s_rdata;
  logic [2:0]      s_dcnt;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err;

  link_arbiter #(
    .N       (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .BEATS   (BEATS),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_ack    (m_ack),
    .m_dvld   (m_dvld),
    .m_rdata  (m_rdata),
    .m_dcnt   (m_dcnt),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_ack    (s_ack),
    .s_dvld   (s_dvld),
    .s_rdata  (s_rdata),
    .s_dcnt   (s_dcnt),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
  } gnt_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic [2:0]    dcnt;
  } beat_t;

  gnt_t          gq[$];
  beat_t         bq[$];
  int            nchk = 0;
  int            nerr = 0;
  logic [AW-1:0] addr_tab [N];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_gnt(input int ch);
    gnt_t e;
    e.ch   = ch;
    e.addr = addr_tab[ch];
    gq.push_back(e);
  endtask

  // Act as the downstream responder for one full burst.
  task automatic serve(input int ack_wait, output int waited);
    gnt_t  e;
    beat_t b;
    int    w;
    w = 0;
    while (s_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    waited = w;
    if (s_req !== 1'b1) begin
      check("sreq_wait", 64'(s_req), 64'd1);
      return;
    end
    if (gq.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = gq.pop_front();
    check("grant", 64'(grant_id), 64'(e.ch));
    check("s_addr", 64'(s_addr), 64'(e.addr));
    check("busy_req", 64'(busy), 64'd1);
    repeat (ack_wait) begin
      check("ack_early", 64'(m_ack), 64'd0);
      tick();
      check("sreq_hold", 64'(s_req), 64'd1);
    end
    s_ack = 1'b1;
    settle();
    check("m_ack", 64'(m_ack), 64'(N'(1) << e.ch));
    tick();
    s_ack = 1'b0;
    settle();
    check("sreq_data", 64'(s_req), 64'd0);
    for (int k = 0; k < BEATS; k++) begin
      b.ch   = e.ch;
      b.data = $urandom;
      b.dcnt = 3'(k);
      bq.push_back(b);
      s_dvld  = 1'b1;
      s_rdata = b.data;
      s_dcnt  = b.dcnt;
      settle();
      b = bq.pop_front();
      check("m_dvld", 64'(m_dvld), 64'(N'(1) << b.ch));
      check("m_rdata", 64'(m_rdata), 64'(b.data));
      check("m_dcnt", 64'(m_dcnt), 64'(b.dcnt));
      tick();
    end
    s_dvld = 1'b0;
    settle();
    check("busy_end", 64'(busy), 64'd0);
    check("sreq_gap", 64'(s_req), 64'd0);
    check("err_none", 64'(err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n   = 1'b0;
    m_req   = '0;
    s_ack   = 1'b0;
    s_dvld  = 1'b1;
    s_dcnt  = 3'd5;
    s_rdata = 32'hdead_beef;
    for (int i = 0; i < N; i++) begin
      addr_tab[i] = 32'h1000 + 32'(i) * 32'h1100;
      m_addr[i*AW +: AW] = addr_tab[i];
    end

    // Reset state, with stray downstream activity present
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_sreq", 64'(s_req), 64'd0);
    check("rst_mack", 64'(m_ack), 64'd0);
    check("rst_mdvld", 64'(m_dvld), 64'd0);
    check("rst_mrdata", 64'(m_rdata), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    s_dvld  = 1'b0;
    s_dcnt  = '0;
    s_rdata = '0;
    rst_n   = 1'b1;

    // Single request, ack on the third REQ cycle
    m_req = 4'b0001;
    push_gnt(0);
    serve(2, w);
    check("req_lat", 64'(w), 64'd1);
    m_req = '0;

    // Fresh pointer, then all four channels contend
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_req = 4'b1111;
    push_gnt(0);
    push_gnt(1);
    push_gnt(2);
    push_gnt(3);
    push_gnt(0);
    repeat (5) begin
      serve(0, w);
      check("rr_lat", 64'(w), 64'd1);
    end
    m_req = '0;

    // Withdrawal: pointer stays at 1, so {2,3} must go to 2 again
    m_req = 4'b0100;
    tick();
    check("wd_grant", 64'(grant_id), 64'd2);
    check("wd_sreq", 64'(s_req), 64'd1);
    m_req = '0;
    tick();
    check("wd_sreq_off", 64'(s_req), 64'd0);
    check("wd_busy", 64'(busy), 64'd0);
    m_req = 4'b1100;
    push_gnt(2);
    serve(0, w);
    m_req = '0;

    // Timeout after ack with a silent responder
    m_req = 4'b1000;
    tick();
    check("to_grant", 64'(grant_id), 64'd3);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m_req = '0;
    for (int k = 0; k < int'(TMO) - 1; k++) begin
      tick();
      check("to_wait_err", 64'(err), 64'd0);
      check("to_wait_busy", 64'(busy), 64'd1);
    end
    tick();
    check("to_err", 64'(err), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    tick();
    check("to_err_pulse", 64'(err), 64'd0);
    m_req = 4'b1001;
    push_gnt(0);
    serve(0, w);
    m_req = '0;

    // Spurious data valid while idle
    s_dvld  = 1'b1;
    s_dcnt  = 3'd2;
    s_rdata = 32'h1234_5678;
    settle();
    check("sp_mdvld", 64'(m_dvld), 64'd0);
    tick();
    s_dvld = 1'b0;
    check("sp_err", 64'(err), 64'd1);
    check("sp_busy", 64'(busy), 64'd0);
    check("sp_sreq", 64'(s_req), 64'd0);
    tick();
    check("sp_err_pulse", 64'(err), 64'd0);
    check("sp_busy2", 64'(busy), 64'd0);

    // Reset asserted on beat 3 of a burst from channel 1
    m_req = 4'b0010;
    tick();
    check("mr_grant", 64'(grant_id), 64'd1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_dvld  = 1'b1;
      s_dcnt  = 3'(k);
      s_rdata = $urandom;
      if (k == 3) rst_n = 1'b0;
      else begin
        settle();
        check("mr_mdvld", 64'(m_dvld), 64'b0010);
      end
      tick();
    end
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_mdvld0", 64'(m_dvld), 64'd0);
    check("mr_mrdata", 64'(m_rdata), 64'd0);
    check("mr_mdcnt", 64'(m_dcnt), 64'd0);
    check("mr_sreq", 64'(s_req), 64'd0);
    check("mr_err", 64'(err), 64'd0);
    check("mr_gid", 64'(grant_id), 64'd0);
    s_dvld = 1'b0;
    rst_n  = 1'b1;
    m_req  = 4'b1111;
    push_gnt(0);
    serve(0, w);
    m_req = '0;

    tick();
    check("sb_drained", 64'(gq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
